// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
package mc_ctrl_pkg;

   // One state per micro-step of the multi-cycle datapath.
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_WB_R     = 4'd3,
      S_EXEC_I   = 4'd4,
      S_WB_I     = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_MEM_RD   = 4'd7,
      S_WB_MEM   = 4'd8,
      S_MEM_WR   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_JR       = 4'd12,
      S_HALT     = 4'd13
   } state_t;

   // Opcode field (instruction[31:26]) values.
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BLEZ  = 6'h06;
   localparam logic [5:0] OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // Function field (instruction[5:0]) value for jr.
   localparam logic [5:0] FN_JR    = 6'h08;

   // ALU operation classes.
   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_RTYPE = 3'd2;
   localparam logic [2:0] ALU_SLT   = 3'd3;
   localparam logic [2:0] ALU_OR    = 3'd4;
   localparam logic [2:0] ALU_LUI   = 3'd5;

   // Next-PC source select.
   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
   localparam logic [1:0] PC_SRC_RS     = 2'd3;

   // ALU B operand select.
   localparam logic [1:0] SRC_B_RT      = 2'd0;
   localparam logic [1:0] SRC_B_FOUR    = 2'd1;
   localparam logic [1:0] SRC_B_IMM     = 2'd2;
   localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

   // Destination register select.
   localparam logic [1:0] REG_DST_RT  = 2'd0;
   localparam logic [1:0] REG_DST_RD  = 2'd1;
   localparam logic [1:0] REG_DST_R31 = 2'd2;

   // Writeback data select.
   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   // ALU class for the immediate-arithmetic group.
   function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
      case (op)
         OP_SLTI: imm_alu_op = ALU_SLT;
         OP_ORI:  imm_alu_op = ALU_OR;
         OP_LUI:  imm_alu_op = ALU_LUI;
         default: imm_alu_op = ALU_ADD;
      endcase
   endfunction

   // Branch outcome from the RS-RT (or RS-0) subtraction flags.
   function automatic logic branch_taken(input logic [5:0] op, input logic zero,
                                         input logic neg);
      case (op)
         OP_BEQ:  branch_taken = zero;
         OP_BNE:  branch_taken = !zero;
         OP_BLEZ: branch_taken = neg | zero;
         OP_BGTZ: branch_taken = !neg & !zero;
         default: branch_taken = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_perf_cnt.sv
// Cycle and retired-instruction counters, both wrapping modulo 2^CNT_W.
module mc_perf_cnt #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc_cycle,
   input  logic             inc_ret,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Synchronous clear wins over both increments.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
      if (clear) begin
         cycle_cnt <= '0;
         instret   <= '0;
      end else begin
         if (inc_cycle) cycle_cnt <= cycle_cnt + ONE;
         if (inc_ret)   instret   <= instret + ONE;
      end
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer: steps each instruction through
// fetch/decode/execute/memory/writeback over one shared memory port.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [5:0]       op_i,
   input  logic [5:0]       funct_i,
   input  logic             zero_i,
   input  logic             neg_i,
   input  logic             mem_ready_i,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic             iord_o,
   output logic             ir_write_o,
   output logic             pc_write_o,
   output logic [1:0]       pc_src_o,
   output logic             alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [2:0]       alu_op_o,
   output logic             ext_sel_o,
   output logic             reg_write_o,
   output logic [1:0]       reg_dst_o,
   output logic [1:0]       mem_to_reg_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] instret_o
);

   state_t state, state_next;
   logic   retire;

   // State register; reset restarts at FETCH, aborting any instruction in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_FETCH;
      else       state <= state_next;
   end

   // Next-state and Moore output decode; op_i comes from the IR, which is
   // stable from DECODE until the next FETCH.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
      state_next   = state;
      retire       = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      iord_o       = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      pc_src_o     = PC_SRC_ALU;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = SRC_B_RT;
      alu_op_o     = ALU_ADD;
      ext_sel_o    = 1'b0;
      reg_write_o  = 1'b0;
      reg_dst_o    = REG_DST_RT;
      mem_to_reg_o = M2R_ALUOUT;
      halted_o     = 1'b0;

      case (state)
         S_FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = SRC_B_FOUR;
            if (mem_ready_i) begin
               ir_write_o = 1'b1;
               pc_write_o = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b_o = SRC_B_IMM_SH2;
            case (op_i)
               OP_RTYPE: state_next = (funct_i == FN_JR) ? S_JR : S_EXEC_R;
               OP_ADDI, OP_SLTI, OP_ORI, OP_LUI: state_next = S_EXEC_I;
               OP_LW, OP_SW: state_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: state_next = S_BRANCH;
               OP_J, OP_JAL: state_next = S_JUMP;
               default: state_next = S_HALT;
            endcase
         end
         S_EXEC_R: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALU_RTYPE;
            state_next  = S_WB_R;
         end
         S_WB_R: begin
            reg_write_o = 1'b1;
            reg_dst_o   = REG_DST_RD;
            retire      = 1'b1;
            state_next  = S_FETCH;
         end
         S_EXEC_I: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRC_B_IMM;
            alu_op_o    = imm_alu_op(op_i);
            ext_sel_o   = (op_i == OP_ORI) || (op_i == OP_LUI);
            state_next  = S_WB_I;
         end
         S_WB_I: begin
            reg_write_o = 1'b1;
            retire      = 1'b1;
            state_next  = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRC_B_IMM;
            state_next  = (op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read_o = 1'b1;
            iord_o     = 1'b1;
            if (mem_ready_i) state_next = S_WB_MEM;
         end
         S_WB_MEM: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = M2R_MDR;
            retire       = 1'b1;
            state_next   = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write_o = 1'b1;
            iord_o      = 1'b1;
            if (mem_ready_i) begin
               retire     = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_BRANCH: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALU_SUB;
            pc_src_o    = PC_SRC_ALUOUT;
            pc_write_o  = branch_taken(op_i, zero_i, neg_i);
            retire      = 1'b1;
            state_next  = S_FETCH;
         end
         S_JUMP: begin
            pc_src_o   = PC_SRC_JUMP;
            pc_write_o = 1'b1;
            if (op_i == OP_JAL) begin
               reg_write_o  = 1'b1;
               reg_dst_o    = REG_DST_R31;
               mem_to_reg_o = M2R_PC;
            end
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_JR: begin
            pc_src_o   = PC_SRC_RS;
            pc_write_o = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_HALT: begin
            halted_o = 1'b1;
         end
         default: begin
            state_next = S_HALT;
         end
      endcase

      // Reset silences every strobe and select immediately, not at the next edge.
      if (rst_i) begin
         mem_read_o   = 1'b0;
         mem_write_o  = 1'b0;
         iord_o       = 1'b0;
         ir_write_o   = 1'b0;
         pc_write_o   = 1'b0;
         pc_src_o     = PC_SRC_ALU;
         alu_src_a_o  = 1'b0;
         alu_src_b_o  = SRC_B_RT;
         alu_op_o     = ALU_ADD;
         ext_sel_o    = 1'b0;
         reg_write_o  = 1'b0;
         reg_dst_o    = REG_DST_RT;
         mem_to_reg_o = M2R_ALUOUT;
         halted_o     = 1'b0;
      end
   end

   mc_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
      .clk       (clk_i),
      .clear     (rst_i),
      .inc_cycle (!rst_i),
      .inc_ret   (retire && !rst_i),
      .cycle_cnt (cycle_cnt_o),
      .instret   (instret_o)
   );

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: the driver pushes hand-written expected
// output vectors per cycle, a negedge monitor pops and compares them.
module tb_mc_ctrl_fsm;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [5:0]  op_i = '0;
   logic [5:0]  funct_i = '0;
   logic        zero_i = 1'b0;
   logic        neg_i = 1'b0;
   logic        mem_ready_i = 1'b1;
   logic        mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o;
   logic [1:0]  pc_src_o;
   logic        alu_src_a_o;
   logic [1:0]  alu_src_b_o;
   logic [2:0]  alu_op_o;
   logic        ext_sel_o, reg_write_o;
   logic [1:0]  reg_dst_o, mem_to_reg_o;
   logic        halted_o;
   logic [31:0] cycle_cnt_o, instret_o;

   mc_ctrl_fsm #(.CNT_W(32)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .op_i         (op_i),
      .funct_i      (funct_i),
      .zero_i       (zero_i),
      .neg_i        (neg_i),
      .mem_ready_i  (mem_ready_i),
      .mem_read_o   (mem_read_o),
      .mem_write_o  (mem_write_o),
      .iord_o       (iord_o),
      .ir_write_o   (ir_write_o),
      .pc_write_o   (pc_write_o),
      .pc_src_o     (pc_src_o),
      .alu_src_a_o  (alu_src_a_o),
      .alu_src_b_o  (alu_src_b_o),
      .alu_op_o     (alu_op_o),
      .ext_sel_o    (ext_sel_o),
      .reg_write_o  (reg_write_o),
      .reg_dst_o    (reg_dst_o),
      .mem_to_reg_o (mem_to_reg_o),
      .halted_o     (halted_o),
      .cycle_cnt_o  (cycle_cnt_o),
      .instret_o    (instret_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       name;
      logic [19:0] vec;
      logic        chk_cnt;
      logic [31:0] cyc;
      logic [31:0] ret;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] exp_cyc = '0;
   logic [31:0] exp_ret = '0;

   // Vector order: mr mw iord irw pcw pcs asa asb aop ext rw rdst m2r halt
   wire [19:0] act_vec = {mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o,
                          pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, ext_sel_o,
                          reg_write_o, reg_dst_o, mem_to_reg_o, halted_o};

   function automatic logic [19:0] mk(input logic mr, mw, io, irw, pcw,
                                      input logic [1:0] pcs, input logic asa,
                                      input logic [1:0] asb, input logic [2:0] aop,
                                      input logic ext, rw, input logic [1:0] rd, m2r,
                                      input logic hlt);
      return {mr, mw, io, irw, pcw, pcs, asa, asb, aop, ext, rw, rd, m2r, hlt};
   endfunction

   // Hand-written per-step expectations.
   function automatic logic [19:0] e_idle();            return mk(0,0,0,0,0,2'd0,0,2'd0,3'd0,0,0,2'd0,2'd0,0); endfunction
   function automatic logic [19:0] e_fetch(input logic r); return mk(1,0,0,r,r,2'd0,0,2'd1,3'd0,0,0,2'd0,2'd0,0); endfunction
   function automatic logic [19:0] e_decode();          return mk(0,0,0,0,0,2'd0,0,2'd3,3'd0,0,0,2'd0,2'd0,0); endfunction
   function automatic logic [19:0] e_exec_r();          return mk(0,0,0,0,0,2'd0,1,2'd0,3'd2,0,0,2'd0,2'd0,0); endfunction
   function automatic logic [19:0] e_wb_r();            return mk(0,0,0,0,0,2'd0,0,2'd0,3'd0,0,1,2'd1,2'd0,0); endfunction
   function automatic logic [19:0] e_exec_i(input logic [2:0] aop, input logic ext);
      return mk(0,0,0,0,0,2'd0,1,2'd2,aop,ext,0,2'd0,2'd0,0);
   endfunction
   function automatic logic [19:0] e_wb_i();            return mk(0,0,0,0,0,2'd0,0,2'd0,3'd0,0,1,2'd0,2'd0,0); endfunction
   function automatic logic [19:0] e_mem_addr();        return mk(0,0,0,0,0,2'd0,1,2'd2,3'd0,0,0,2'd0,2'd0,0); endfunction
   function automatic logic [19:0] e_mem_rd();          return mk(1,0,1,0,0,2'd0,0,2'd0,3'd0,0,0,2'd0,2'd0,0); endfunction
   function automatic logic [19:0] e_wb_mem();          return mk(0,0,0,0,0,2'd0,0,2'd0,3'd0,0,1,2'd0,2'd1,0); endfunction
   function automatic logic [19:0] e_mem_wr();          return mk(0,1,1,0,0,2'd0,0,2'd0,3'd0,0,0,2'd0,2'd0,0); endfunction
   function automatic logic [19:0] e_branch(input logic t); return mk(0,0,0,0,t,2'd1,1,2'd0,3'd1,0,0,2'd0,2'd0,0); endfunction
   function automatic logic [19:0] e_j();               return mk(0,0,0,0,1,2'd2,0,2'd0,3'd0,0,0,2'd0,2'd0,0); endfunction
   function automatic logic [19:0] e_jal();             return mk(0,0,0,0,1,2'd2,0,2'd0,3'd0,0,1,2'd2,2'd2,0); endfunction
   function automatic logic [19:0] e_jr();              return mk(0,0,0,0,1,2'd3,0,2'd0,3'd0,0,0,2'd0,2'd0,0); endfunction
   function automatic logic [19:0] e_halt();            return mk(0,0,0,0,0,2'd0,0,2'd0,3'd0,0,0,2'd0,2'd0,1); endfunction

   // Drive one cycle of inputs and queue what the DUT must show in that cycle.
   task automatic step(input string name, input logic rst, input logic [5:0] op,
                       input logic [5:0] fn, input logic z, input logic n,
                       input logic rdy, input logic [19:0] vec, input logic ret);
      exp_t e;
      @(posedge clk_i);
      #1;
      rst_i = rst; op_i = op; funct_i = fn; zero_i = z; neg_i = n; mem_ready_i = rdy;
      e.name = name;
      e.vec  = vec;
      if (rst) begin
         e.chk_cnt = 1'b0;
         e.cyc     = '0;
         e.ret     = '0;
         exp_cyc   = '0;
         exp_ret   = '0;
      end else begin
         e.chk_cnt = 1'b1;
         e.cyc     = exp_cyc;
         e.ret     = exp_ret;
         exp_cyc   = exp_cyc + 32'd1;
         if (ret) exp_ret = exp_ret + 32'd1;
      end
      sb_q.push_back(e);
   endtask

   task automatic run_r(input string nm, input logic [5:0] fn);
      step({nm, "_fetch"},  0, 6'h00, fn, 0, 0, 1, e_fetch(1), 0);
      step({nm, "_decode"}, 0, 6'h00, fn, 0, 0, 1, e_decode(), 0);
      step({nm, "_exec"},   0, 6'h00, fn, 0, 0, 1, e_exec_r(), 0);
      step({nm, "_wb"},     0, 6'h00, fn, 0, 0, 1, e_wb_r(),   1);
   endtask

   task automatic run_i(input string nm, input logic [5:0] op, input logic [2:0] aop,
                        input logic ext);
      step({nm, "_fetch"},  0, op, 6'h00, 0, 0, 1, e_fetch(1),        0);
      step({nm, "_decode"}, 0, op, 6'h00, 0, 0, 1, e_decode(),        0);
      step({nm, "_exec"},   0, op, 6'h00, 0, 0, 1, e_exec_i(aop, ext), 0);
      step({nm, "_wb"},     0, op, 6'h00, 0, 0, 1, e_wb_i(),          1);
   endtask

   task automatic run_br(input string nm, input logic [5:0] op, input logic z,
                         input logic n, input logic taken);
      step({nm, "_fetch"},  0, op, 6'h00, z, n, 1, e_fetch(1),      0);
      step({nm, "_decode"}, 0, op, 6'h00, z, n, 1, e_decode(),      0);
      step({nm, "_branch"}, 0, op, 6'h00, z, n, 1, e_branch(taken), 1);
   endtask

   // Monitor: compare outputs and counters against the oldest queued entry.
   always @(negedge clk_i) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         n_checks++;
         if (act_vec !== e.vec)
            $display("FAIL %s: outputs got %b expected %b", e.name, act_vec, e.vec);
         else
            n_pass++;
         if (e.chk_cnt) begin
            n_checks++;
            if (cycle_cnt_o !== e.cyc || instret_o !== e.ret)
               $display("FAIL %s_cnt: cycle/instret got %0d/%0d expected %0d/%0d",
                        e.name, cycle_cnt_o, instret_o, e.cyc, e.ret);
            else
               n_pass++;
         end
      end
   end

   initial begin
      // Reset held three cycles with memory ready; strobes must stay low.
      repeat (3) step("reset", 1, 6'h00, 6'h20, 0, 0, 1, e_idle(), 0);

      // add, zero-wait memory: 4 cycles.
      run_r("add", 6'h20);

      // lw with two wait cycles in MEM_RD: 7 cycles.
      step("lw_fetch",  0, 6'h23, 6'h00, 0, 0, 1, e_fetch(1),   0);
      step("lw_decode", 0, 6'h23, 6'h00, 0, 0, 1, e_decode(),   0);
      step("lw_addr",   0, 6'h23, 6'h00, 0, 0, 1, e_mem_addr(), 0);
      step("lw_rd_w0",  0, 6'h23, 6'h00, 0, 0, 0, e_mem_rd(),   0);
      step("lw_rd_w1",  0, 6'h23, 6'h00, 0, 0, 0, e_mem_rd(),   0);
      step("lw_rd_rdy", 0, 6'h23, 6'h00, 0, 0, 1, e_mem_rd(),   0);
      step("lw_wb",     0, 6'h23, 6'h00, 0, 0, 1, e_wb_mem(),   1);

      // Branch conditions, taken and not taken.
      run_br("bne_z1",  6'h05, 1, 0, 0);
      run_br("bne_z0",  6'h05, 0, 0, 1);
      run_br("beq_z1",  6'h04, 1, 0, 1);
      run_br("blez_n1", 6'h06, 0, 1, 1);
      run_br("bgtz_p",  6'h07, 0, 0, 1);
      run_br("bgtz_z",  6'h07, 1, 0, 0);

      // Immediate group: ALU class and zero-extension per opcode.
      run_i("addi", 6'h08, 3'd0, 0);
      run_i("slti", 6'h0A, 3'd3, 0);
      run_i("ori",  6'h0D, 3'd4, 1);
      run_i("lui",  6'h0F, 3'd5, 1);

      // sw with a one-cycle fetch stall, zero-wait store.
      step("sw_fetch_w", 0, 6'h2B, 6'h00, 0, 0, 0, e_fetch(0),   0);
      step("sw_fetch",   0, 6'h2B, 6'h00, 0, 0, 1, e_fetch(1),   0);
      step("sw_decode",  0, 6'h2B, 6'h00, 0, 0, 1, e_decode(),   0);
      step("sw_addr",    0, 6'h2B, 6'h00, 0, 0, 1, e_mem_addr(), 0);
      step("sw_wr",      0, 6'h2B, 6'h00, 0, 0, 1, e_mem_wr(),   1);

      // jal, j, then jr.
      step("jal_fetch",  0, 6'h03, 6'h00, 0, 0, 1, e_fetch(1), 0);
      step("jal_decode", 0, 6'h03, 6'h00, 0, 0, 1, e_decode(), 0);
      step("jal_jump",   0, 6'h03, 6'h00, 0, 0, 1, e_jal(),    1);
      step("j_fetch",    0, 6'h02, 6'h00, 0, 0, 1, e_fetch(1), 0);
      step("j_decode",   0, 6'h02, 6'h00, 0, 0, 1, e_decode(), 0);
      step("j_jump",     0, 6'h02, 6'h00, 0, 0, 1, e_j(),      1);
      step("jr_fetch",   0, 6'h00, 6'h08, 0, 0, 1, e_fetch(1), 0);
      step("jr_decode",  0, 6'h00, 6'h08, 0, 0, 1, e_decode(), 0);
      step("jr_jr",      0, 6'h00, 6'h08, 0, 0, 1, e_jr(),     1);

      // Illegal opcode traps; HALT stays silent while cycles keep counting.
      step("ill_fetch",  0, 6'h3F, 6'h00, 0, 0, 1, e_fetch(1), 0);
      step("ill_decode", 0, 6'h3F, 6'h00, 0, 0, 1, e_decode(), 0);
      repeat (10) step("halt", 0, 6'h3F, 6'h00, 0, 0, 1, e_halt(), 0);

      // Reset leaves HALT; then abort a stalled sw mid-MEM_WR.
      step("rst_halt",   1, 6'h2B, 6'h00, 0, 0, 1, e_idle(),     0);
      step("sw2_fetch",  0, 6'h2B, 6'h00, 0, 0, 1, e_fetch(1),   0);
      step("sw2_decode", 0, 6'h2B, 6'h00, 0, 0, 1, e_decode(),   0);
      step("sw2_addr",   0, 6'h2B, 6'h00, 0, 0, 1, e_mem_addr(), 0);
      step("sw2_wr_w0",  0, 6'h2B, 6'h00, 0, 0, 0, e_mem_wr(),   0);
      step("rst_mid_wr", 1, 6'h2B, 6'h00, 0, 0, 1, e_idle(),     0);
      step("post_fetch", 0, 6'h00, 6'h20, 0, 0, 1, e_fetch(1),   0);
      step("post_decode",0, 6'h00, 6'h20, 0, 0, 1, e_decode(),   0);

      // Let the monitor drain the queue, within a bounded number of cycles.
      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk_i);
      if (sb_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d entries left expected 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
